// File: rtl/patgen_pkg.sv
// Shared types and default sizing for the pattern player.
// The FSM state enum and the sample-period counter width live here so the
// top level and any future siblings agree on them.
package patgen_pkg;

    localparam int PG_DATA_W = 8;   // sample width
    localparam int PG_DEPTH  = 16;  // pattern memory depth (power of 2)
    localparam int PG_ADDR_W = 4;   // log2(PG_DEPTH)
    localparam int PG_DIV_W  = 4;   // width of the sample-period divider

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_PLAY = 2'd1,
        PG_DONE = 2'd2
    } pg_state_e;

endpackage : patgen_pkg

// File: rtl/patgen_start_sync.sv
// Brings the asynchronous start level into the clk domain through two flops
// and produces a single-cycle pulse on its rising edge.
module patgen_start_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic start_async,
    output logic start_pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Two-stage synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= start_async;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign start_pulse = sync2_reg & ~prev_reg;

endmodule : patgen_start_sync

// File: rtl/pattern_player.sv
// Pattern player: software preloads DEPTH samples through the write port, a
// rising edge on start replays them on pat_out at one sample every (div+1)
// clocks. busy marks playback, done marks a completed single-shot pass.
// Build option: define PATGEN_LOOP_EN to honour the loop input; without it
// every pass is single-shot and ends in DONE.
module pattern_player
    import patgen_pkg::*;
#(
    parameter int DATA_W = PG_DATA_W,
    parameter int DEPTH  = PG_DEPTH,   // must be a power of 2
    parameter int ADDR_W = PG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic [PG_DIV_W-1:0] div,
    output logic [DATA_W-1:0]   pat_out,
    output logic                pat_valid,
    output logic                busy,
    output logic                done
);

    // Pattern storage; flop-based because reset must clear it
    logic [DATA_W-1:0]   mem_reg [DEPTH];
    logic [DEPTH-1:0]    wr_sel;

    pg_state_e           state_reg,     state_next;
    logic [ADDR_W-1:0]   rd_ptr_reg,    rd_ptr_next;
    logic [PG_DIV_W-1:0] div_cnt_reg,   div_cnt_next;
    logic [DATA_W-1:0]   pat_out_reg,   pat_out_next;
    logic                pat_valid_reg, pat_valid_next;
    logic                done_reg,      done_next;
    // Set when the final sample of a single-shot pass has just been emitted;
    // PLAY lingers one more cycle so that sample is shown while busy is high
    logic                last_reg,      last_next;

    logic                start_pulse;
    logic                loop_en;

    patgen_start_sync u_start_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_async (start),
        .start_pulse (start_pulse)
    );

`ifdef PATGEN_LOOP_EN
    assign loop_en = loop;
`else
    // loop stays in the port list for a uniform interface but has no effect
    assign loop_en = loop & 1'b0;
`endif

    // One-hot write decode, one select line per memory word
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    // Pattern memory: accepts writes in every state; a read in the same cycle sees old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

    // Playback FSM: start/restart, stop abort, sample pacing and end-of-pass handling
    always_comb begin
        state_next     = state_reg;
        rd_ptr_next    = rd_ptr_reg;
        div_cnt_next   = div_cnt_reg;
        pat_out_next   = pat_out_reg;
        pat_valid_next = 1'b0;
        done_next      = done_reg;
        last_next      = last_reg;

        case (state_reg)
            PG_IDLE, PG_DONE: begin
                // stop in the same cycle as a start edge keeps us parked
                if (start_pulse && !stop) begin
                    state_next   = PG_PLAY;
                    rd_ptr_next  = '0;
                    div_cnt_next = '0;
                    done_next    = 1'b0;
                    last_next    = 1'b0;
                end
            end

            PG_PLAY: begin
                if (stop) begin
                    state_next = PG_IDLE;
                    last_next  = 1'b0;
                end else if (start_pulse) begin
                    rd_ptr_next  = '0;
                    div_cnt_next = '0;
                    last_next    = 1'b0;
                end else if (last_reg) begin
                    state_next = PG_DONE;
                    done_next  = 1'b1;
                    last_next  = 1'b0;
                end else if (div_cnt_reg == '0) begin
                    pat_out_next   = mem_reg[rd_ptr_reg];
                    pat_valid_next = 1'b1;
                    div_cnt_next   = div;
                    rd_ptr_next    = rd_ptr_reg + ADDR_W'(1);
                    if ((rd_ptr_reg == ADDR_W'(DEPTH - 1)) && !loop_en) begin
                        last_next = 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg - PG_DIV_W'(1);
                end
            end

            default: begin
                state_next = PG_IDLE;
            end
        endcase
    end

    // State, pointer, divider and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PG_IDLE;
            rd_ptr_reg    <= '0;
            div_cnt_reg   <= '0;
            pat_out_reg   <= '0;
            pat_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_ptr_reg    <= rd_ptr_next;
            div_cnt_reg   <= div_cnt_next;
            pat_out_reg   <= pat_out_next;
            pat_valid_reg <= pat_valid_next;
            done_reg      <= done_next;
            last_reg      <= last_next;
        end
    end

    assign pat_out   = pat_out_reg;
    assign pat_valid = pat_valid_reg;
    assign busy      = (state_reg == PG_PLAY);
    assign done      = done_reg;

endmodule : pattern_player

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player. A behavioural model (an array of
// expected samples) predicts every emitted value; pacing and flag timing are
// checked against the sample-period rule.
module tb_pattern_player;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       stop;
    logic       loop;
    logic [3:0] div;
    logic [7:0] pat_out;
    logic       pat_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [16];

    pattern_player dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .div       (div),
        .pat_out   (pat_out),
        .pat_valid (pat_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single write, applied away from the clock edge and captured by the next posedge
    task automatic mem_write(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    // mode 0: 0x10+i, mode 1: random
    task automatic load_mem(input int mode);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = (mode == 0) ? 8'(8'h10 + i) : 8'($urandom);
            mem_write(4'(i), d);
            ref_mem[i] = d;
        end
    endtask

    // Hold start high for three cycles so the synchronizer sees one rising edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    // Advance to the next negedge with pat_valid high; gap = cycles advanced
    task automatic wait_valid(output bit ok, output int gap);
        ok  = 1'b0;
        gap = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            gap++;
            if (pat_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Receive n samples, compare against the model and check pacing of div+1
    task automatic collect(input string tag, input int n, input int div_v);
        bit ok;
        int gap;
        for (int i = 0; i < n; i++) begin
            wait_valid(ok, gap);
            if (!ok) begin
                chk({tag, "_timeout"}, 32'd0, 32'd1);
                return;
            end
            $display("[%s] sample %0d out=%02h exp=%02h gap=%0d", tag, i, pat_out, ref_mem[i % 16], gap);
            chk({tag, "_val"}, 32'(pat_out), 32'(ref_mem[i % 16]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (i > 0) chk({tag, "_gap"}, 32'(gap), 32'(div_v + 1));
        end
    endtask

    task automatic check_done(input string tag, input logic [7:0] exp_last);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
        chk({tag, "_valid0"}, 32'(pat_valid), 32'd0);
        chk({tag, "_hold"}, 32'(pat_out), 32'(exp_last));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int gap;
        int bad;
        logic [7:0] old5;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0; div = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        // T1 reset and idle
        repeat (3) @(negedge clk);
        chk("rst_pat_out", 32'(pat_out), 32'd0);
        chk("rst_valid", 32'(pat_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy || done || pat_valid || pat_out != 8'h00) bad++;
        end
        $display("[T1] idle cycles with activity=%0d", bad);
        chk("idle_100", 32'(bad), 32'd0);

        // T5a stop together with the start edge keeps the player idle
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; stop = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || pat_valid) bad++;
        end
        $display("[T5a] active cycles after stop+start=%0d", bad);
        chk("stop_start_idle", 32'(bad), 32'd0);

        // T2 single shot, div=0
        load_mem(0);
        div = 4'd0;
        pulse_start();
        collect("t2", 16, 0);
        check_done("t2", ref_mem[15]);

        // T3 div=3 with random data, then random periods
        load_mem(1);
        div = 4'd3;
        pulse_start();
        collect("t3", 16, 3);
        check_done("t3", ref_mem[15]);
        for (int r = 0; r < 2; r++) begin
            load_mem(1);
            div = 4'($urandom_range(0, 15));
            pulse_start();
            collect("t3r", 16, int'(div));
            check_done("t3r", ref_mem[15]);
        end

        // T4 loop
        load_mem(0);
        div = 4'd0;
        loop = 1'b1;
        pulse_start();
`ifdef PATGEN_LOOP_EN
        collect("t4", 40, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 32'd0);
        chk("t4_stop_done", 32'(done), 32'd0);
        chk("t4_stop_valid", 32'(pat_valid), 32'd0);
        chk("t4_stop_hold", 32'(pat_out), 32'h17);
`else
        collect("t4", 16, 0);
        check_done("t4", ref_mem[15]);
`endif
        loop = 1'b0;

        // T5b start during play restarts from sample 0
        div = 4'd3;
        pulse_start();
        collect("t5b_pre", 5, 3);
        pulse_start();
        collect("t5b", 16, 3);
        check_done("t5b", ref_mem[15]);

        // T5c overwrite the address being read: old data now, new data next pass
        pulse_start();
        old5 = ref_mem[5];
        for (int i = 0; i < 16; i++) begin
            wait_valid(ok, gap);
            if (!ok) begin
                chk("t5c_timeout", 32'd0, 32'd1);
                break;
            end
            $display("[t5c] sample %0d out=%02h exp=%02h", i, pat_out, ref_mem[i]);
            chk("t5c_val", 32'(pat_out), 32'(ref_mem[i]));
            if (i == 4) begin
                repeat (3) @(negedge clk);
                mem_write(4'd5, 8'hAA);
            end
        end
        check_done("t5c", ref_mem[15]);
        chk("t5c_old_kept", 32'(ref_mem[5]), 32'(old5));
        ref_mem[5] = 8'hAA;
        pulse_start();
        collect("t5c_next", 16, 3);
        check_done("t5c_next", ref_mem[15]);

        // T6 reset mid-play clears everything including the memory
        div = 4'd0;
        pulse_start();
        collect("t6_pre", 5, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", 32'(pat_out), 32'd0);
        chk("t6_rst_valid", 32'(pat_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        collect("t6", 16, 0);
        check_done("t6", 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pattern_player
